// File: rtl/ukf_pkg.sv
// Shared fixed-point constants and predict-step FSM encoding for the UKF datapath.
package ukf_pkg;

  localparam int UKF_DATA_W    = 32;
  localparam int UKF_INT_BITS  = 2;
  localparam int UKF_FRAC_BITS = 30;
  localparam int UKF_GUARD     = 4;
  localparam int UKF_ACC_W     = UKF_DATA_W + UKF_GUARD;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    SAT   = 2'd2,
    OUT   = 2'd3
  } state_t;

endpackage

// File: rtl/sigma_mean_acc_mul.sv
// Combinational signed Q-format multiply: full product, floor shift by FRAC_BITS,
// result sign-extended (or wrapped) to ACC_W bits.
module sigma_mean_acc_mul
  import ukf_pkg::*;
#(
  parameter int DATA_W    = UKF_DATA_W,
  parameter int FRAC_BITS = UKF_FRAC_BITS,
  parameter int ACC_W     = UKF_ACC_W
) (
  input  logic signed [DATA_W-1:0] a,
  input  logic signed [DATA_W-1:0] b,
  output logic signed [ACC_W-1:0]  p
);

  // Product width is chosen so the ACC_W slice above FRAC_BITS is directly the
  // sign-extended, floor-shifted result; it must cover the full 2*DATA_W product.
  localparam int PW = FRAC_BITS + ACC_W;

  logic signed [PW-1:0] a_x;
  logic signed [PW-1:0] b_x;
  logic signed [PW-1:0] prod;
  logic                 unused_lsb;

  assign a_x        = {{(PW-DATA_W){a[DATA_W-1]}}, a};
  assign b_x        = {{(PW-DATA_W){b[DATA_W-1]}}, b};
  assign prod       = a_x * b_x;
  assign p          = prod[FRAC_BITS +: ACC_W];
  assign unused_lsb = ^prod[FRAC_BITS-1:0];

endmodule

// File: rtl/sigma_mean_acc.sv
// Weighted-mean accumulator for the UKF predict step: two-lane sigma-point
// weighting, per-component accumulation, then saturation to the output word.
module sigma_mean_acc
  import ukf_pkg::*;
#(
  parameter int N_STATE   = 6,
  parameter int DATA_W    = UKF_DATA_W,
  parameter int INT_BITS  = UKF_INT_BITS,
  parameter int FRAC_BITS = UKF_FRAC_BITS,
  parameter int GUARD     = UKF_GUARD
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic                      start,
  input  logic [DATA_W-1:0]         w0m,
  input  logic [DATA_W-1:0]         w,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [DATA_W-1:0]         in_a,
  input  logic [DATA_W-1:0]         in_b,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [N_STATE*DATA_W-1:0] mean,
  output logic                      busy
);

  // State | meaning
  // IDLE  | waiting for start; weights and accumulators are reloaded on start
  // ACCUM | accepting beats, component-minor order, 2 lanes per beat
  // SAT   | one cycle: clamp every accumulator into the output word
  // OUT   | mean held with out_valid until the consumer takes it

  localparam int ACC_W = DATA_W + GUARD;
  localparam int JW    = $clog2(N_STATE + 1);
  localparam int CW    = (N_STATE > 1) ? $clog2(N_STATE) : 1;

  localparam logic [JW-1:0] J_LAST = JW'(N_STATE);
  localparam logic [CW-1:0] C_LAST = CW'(N_STATE - 1);

  if (INT_BITS + FRAC_BITS != DATA_W) begin : g_bad_qfmt
    $error("sigma_mean_acc: INT_BITS + FRAC_BITS must equal DATA_W");
  end

  state_t                   state_q;
  logic [JW-1:0]            j_cnt_q;
  logic [CW-1:0]            c_cnt_q;
  logic [DATA_W-1:0]        w0m_q;
  logic [DATA_W-1:0]        w_q;
  logic [ACC_W-1:0]         acc_q  [N_STATE];
  logic [DATA_W-1:0]        mean_q [N_STATE];
  logic                     in_ready_q;
  logic                     out_valid_q;
  logic                     busy_q;

  logic [DATA_W-1:0]        ws;
  logic signed [ACC_W-1:0]  pa;
  logic signed [ACC_W-1:0]  pb;
  logic [ACC_W-1:0]         acc_d;

  function automatic logic [DATA_W-1:0] sat(input logic [ACC_W-1:0] x);
    logic [GUARD:0] top;
    top = x[ACC_W-1:DATA_W-1];
    if ((&top) || !(|top)) return x[DATA_W-1:0];
    else if (x[ACC_W-1])   return {1'b1, {(DATA_W-1){1'b0}}};
    else                   return {1'b0, {(DATA_W-1){1'b1}}};
  endfunction

  assign ws = (j_cnt_q == '0) ? w0m_q : w_q;

  sigma_mean_acc_mul #(
    .DATA_W   (DATA_W),
    .FRAC_BITS(FRAC_BITS),
    .ACC_W    (ACC_W)
  ) u_mul_a (
    .a(in_a),
    .b(ws),
    .p(pa)
  );

  sigma_mean_acc_mul #(
    .DATA_W   (DATA_W),
    .FRAC_BITS(FRAC_BITS),
    .ACC_W    (ACC_W)
  ) u_mul_b (
    .a(in_b),
    .b(ws),
    .p(pb)
  );

  // Wraps at ACC_W; the guard bits keep a legal frame from overflowing.
  assign acc_d = acc_q[c_cnt_q] + pa + pb;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= IDLE;
      j_cnt_q     <= '0;
      c_cnt_q     <= '0;
      w0m_q       <= '0;
      w_q         <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      for (int i = 0; i < N_STATE; i++) begin
        acc_q[i]  <= '0;
        mean_q[i] <= '0;
      end
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q    <= ACCUM;
            w0m_q      <= w0m;
            w_q        <= w;
            j_cnt_q    <= '0;
            c_cnt_q    <= '0;
            in_ready_q <= 1'b1;
            busy_q     <= 1'b1;
            for (int i = 0; i < N_STATE; i++) acc_q[i] <= '0;
          end
        end
        ACCUM: begin
          if (in_valid) begin
            acc_q[c_cnt_q] <= acc_d;
            if (c_cnt_q == C_LAST) begin
              c_cnt_q <= '0;
              if (j_cnt_q == J_LAST) begin
                j_cnt_q    <= '0;
                in_ready_q <= 1'b0;
                state_q    <= SAT;
              end else begin
                j_cnt_q <= j_cnt_q + JW'(1);
              end
            end else begin
              c_cnt_q <= c_cnt_q + CW'(1);
            end
          end
        end
        SAT: begin
          for (int i = 0; i < N_STATE; i++) mean_q[i] <= sat(acc_q[i]);
          out_valid_q <= 1'b1;
          state_q     <= OUT;
        end
        OUT: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: begin
          state_q     <= IDLE;
          in_ready_q  <= 1'b0;
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    mean = '0;
    for (int i = 0; i < N_STATE; i++) mean[i*DATA_W +: DATA_W] = mean_q[i];
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_sigma_mean_acc.sv
// Directed bench for sigma_mean_acc: table of frames with hand-computed means,
// plus flow-control and mid-frame reset sequences.
module tb_sigma_mean_acc;

  localparam int N  = 6;
  localparam int DW = 32;
  localparam int NB = (N + 1) * N;

  logic          clk = 1'b0;
  logic          rstn;
  logic          start;
  logic [DW-1:0] w0m;
  logic [DW-1:0] w;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_a;
  logic [DW-1:0] in_b;
  logic          out_valid;
  logic          out_ready;
  logic [N*DW-1:0] mean;
  logic          busy;

  int total = 0;
  int bad   = 0;

  typedef struct {
    string       name;
    logic [31:0] w0m;
    logic [31:0] w;
    logic [31:0] ca  [N];
    logic [31:0] cb  [N];
    logic [31:0] exp [N];
  } vec_t;

  vec_t vecs [5];

  sigma_mean_acc #(.N_STATE(N), .DATA_W(DW), .INT_BITS(2), .FRAC_BITS(30), .GUARD(4)) dut (
    .clk      (clk),
    .rstn     (rstn),
    .start    (start),
    .w0m      (w0m),
    .w        (w),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_a     (in_a),
    .in_b     (in_b),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .mean     (mean),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_frame(input vec_t v, input bit gaps, input int hold);
    int  k;
    int  guard;
    int  lat;
    bit  stray_done;
    out_ready = (hold == 0);
    w0m   = v.w0m;
    w     = v.w;
    start = 1'b1;
    tick();
    start = 1'b0;
    // junk on the weight inputs: the frame must keep using the latched ones
    w0m   = 32'h7FFF_FFFF;
    w     = 32'h7FFF_FFFF;
    chk({v.name, " in_ready after start"}, {31'd0, in_ready}, 32'd1);
    chk({v.name, " busy after start"}, {31'd0, busy}, 32'd1);
    k = 0;
    guard = 0;
    stray_done = 1'b0;
    while (k < NB && guard < 1000) begin
      guard++;
      if (gaps && ((k == 10 && !stray_done) || $urandom_range(0, 2) == 0)) begin
        in_valid = 1'b0;
        in_a     = 32'hDEAD_BEEF;
        in_b     = 32'hDEAD_BEEF;
        start    = (k == 10 && !stray_done);
        if (k == 10) stray_done = 1'b1;
        tick();
        start = 1'b0;
      end else begin
        in_valid = 1'b1;
        in_a     = v.ca[k % N];
        in_b     = v.cb[k % N];
        tick();
        in_valid = 1'b0;
        k++;
      end
    end
    chk({v.name, " beats accepted"}, k, NB);
    // lat counts edges from the one that accepted the last beat
    lat = 1;
    while (!out_valid && lat < 10) begin
      tick();
      lat++;
    end
    chk({v.name, " latency"}, lat, 2);
    chk({v.name, " in_ready in OUT"}, {31'd0, in_ready}, 32'd0);
    for (int c = 0; c < N; c++)
      chk($sformatf("%s mean[%0d]", v.name, c), mean[c*DW +: DW], v.exp[c]);
    for (int h = 0; h < hold; h++) begin
      tick();
      chk($sformatf("%s hold%0d out_valid", v.name, h), {31'd0, out_valid}, 32'd1);
      chk($sformatf("%s hold%0d mean[0]", v.name, h), mean[0 +: DW], v.exp[0]);
      chk($sformatf("%s hold%0d mean[%0d]", v.name, h, N-1), mean[(N-1)*DW +: DW], v.exp[N-1]);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk({v.name, " out_valid dropped"}, {31'd0, out_valid}, 32'd0);
    chk({v.name, " busy dropped"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    vecs[0].name = "nominal";
    vecs[0].w0m  = 32'h1000_0000;
    vecs[0].w    = 32'h0800_0000;
    vecs[1].name = "negative";
    vecs[1].w0m  = 32'h1000_0000;
    vecs[1].w    = 32'h0800_0000;
    vecs[2].name = "sat_pos";
    vecs[2].w0m  = 32'h2000_0000;
    vecs[2].w    = 32'h2000_0000;
    vecs[3].name = "sat_neg";
    vecs[3].w0m  = 32'h2000_0000;
    vecs[3].w    = 32'h2000_0000;
    vecs[4].name = "routing";
    vecs[4].w0m  = 32'h1000_0000;
    vecs[4].w    = 32'h0800_0000;
    for (int c = 0; c < N; c++) begin
      vecs[0].ca[c] = 32'h2000_0000; vecs[0].cb[c] = 32'h2000_0000; vecs[0].exp[c] = 32'h4000_0000;
      vecs[1].ca[c] = 32'hE000_0000; vecs[1].cb[c] = 32'hE000_0000; vecs[1].exp[c] = 32'hC000_0000;
      vecs[2].ca[c] = 32'h7FFF_FFFF; vecs[2].cb[c] = 32'h7FFF_FFFF; vecs[2].exp[c] = 32'h7FFF_FFFF;
      vecs[3].ca[c] = 32'h8000_0000; vecs[3].cb[c] = 32'h8000_0000; vecs[3].exp[c] = 32'h8000_0000;
      vecs[4].ca[c] = 32'(c) * 32'h0100_0000;
      vecs[4].cb[c] = 32'(c) * 32'h0100_0000;
      vecs[4].exp[c] = 32'(2 * c) * 32'h0100_0000;
    end

    rstn      = 1'b0;
    start     = 1'b0;
    w0m       = '0;
    w         = '0;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    out_ready = 1'b0;
    #23;
    chk("reset in_ready", {31'd0, in_ready}, 32'd0);
    chk("reset out_valid", {31'd0, out_valid}, 32'd0);
    chk("reset busy", {31'd0, busy}, 32'd0);
    for (int c = 0; c < N; c++) chk($sformatf("reset mean[%0d]", c), mean[c*DW +: DW], 32'd0);
    // in_valid while idle must not move anything
    in_valid = 1'b1;
    in_a     = 32'h2000_0000;
    in_b     = 32'h2000_0000;
    rstn     = 1'b1;
    tick();
    tick();
    in_valid = 1'b0;
    chk("idle in_valid busy", {31'd0, busy}, 32'd0);

    // back-to-back frames: out_ready already high, next start in first IDLE cycle
    for (int i = 0; i < 5; i++) run_frame(vecs[i], 1'b0, 0);

    // gaps, stray start during ACCUM, consumer stalls 5 cycles
    run_frame(vecs[4], 1'b1, 5);

    // mid-frame reset
    w0m   = 32'h1000_0000;
    w     = 32'h0800_0000;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 20; k++) begin
      in_valid = 1'b1;
      in_a     = 32'h2000_0000;
      in_b     = 32'h2000_0000;
      tick();
    end
    in_valid = 1'b0;
    #2;
    rstn = 1'b0;
    #1;
    chk("midreset in_ready", {31'd0, in_ready}, 32'd0);
    chk("midreset out_valid", {31'd0, out_valid}, 32'd0);
    chk("midreset busy", {31'd0, busy}, 32'd0);
    tick();
    @(negedge clk);
    rstn = 1'b1;
    for (int h = 0; h < 4; h++) begin
      tick();
      chk($sformatf("post-reset out_valid %0d", h), {31'd0, out_valid}, 32'd0);
    end
    run_frame(vecs[0], 1'b0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
